// File: rtl/rr_dmux8_arbiter_if.sv
// Request/grant bundle between the eight requesters and the shared DMux8Way path.
// master = requester side, slave = arbiter side.
interface rr_dmux8_arbiter_if;
   logic [7:0] req;
   logic       done;
   logic [7:0] grant;
   logic [2:0] sel;
   logic       busy;
   logic       timeout;

   modport master (output req, output done,
                   input grant, input sel, input busy, input timeout);
   modport slave  (input req, input done,
                   output grant, output sel, output busy, output timeout);
endinterface

// File: rtl/rr_dmux8_arbiter.sv
// Round-robin owner of the shared 8-way demux path; one-edge grant latency,
// grant held until done / request drop / MAX_HOLD, with one idle cycle between owners.
module rr_dmux8_arbiter #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   rr_dmux8_arbiter_if.slave   bus
);

   typedef enum logic {IDLE, OWN} state_t;

   state_t           state;
   logic [2:0]       ptr;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       grant_q;
   logic [2:0]       sel_q;
   logic             busy_q;
   logic             timeout_q;

   logic [2:0]       winner;
   logic             found;
   logic [2:0]       idx;
   logic             release_now;
   logic             forced;

   // Scan from ptr upward with 3-bit wrap; first requester found wins.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int i = 0; i < 8; i++) begin
         idx = ptr + 3'(i);
         if (!found && bus.req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   assign forced      = (cnt == CNT_W'(MAX_HOLD - 1));
   assign release_now = bus.done || !bus.req[sel_q] || forced;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         cnt       <= '0;
         grant_q   <= '0;
         sel_q     <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               timeout_q <= 1'b0;
               if (found) begin
                  grant_q <= 8'(1) << winner;
                  sel_q   <= winner;
                  busy_q  <= 1'b1;
                  cnt     <= '0;
                  state   <= OWN;
               end
            end
            OWN: begin
               if (release_now) begin
                  grant_q   <= '0;
                  sel_q     <= '0;
                  busy_q    <= 1'b0;
                  ptr       <= sel_q + 3'd1;
                  // Only a pure hold-limit release is reported as a timeout.
                  timeout_q <= forced && !bus.done && bus.req[sel_q];
                  state     <= IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.grant   = grant_q;
   assign bus.sel     = sel_q;
   assign bus.busy    = busy_q;
   assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_dmux8_arbiter.sv
// Directed vectors for rr_dmux8_arbiter with MAX_HOLD=4.
module tb_rr_dmux8_arbiter;
   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   rr_dmux8_arbiter_if arb_if ();

   rr_dmux8_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (arb_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [7:0] g, input logic [2:0] s,
                            input logic b, input logic t);
      check({tag, ".grant"},   16'(arb_if.grant),   16'(g));
      check({tag, ".sel"},     16'(arb_if.sel),     16'(s));
      check({tag, ".busy"},    16'(arb_if.busy),    16'(b));
      check({tag, ".timeout"}, 16'(arb_if.timeout), 16'(t));
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      arb_if.req  = 8'hFF;
      arb_if.done = 1'b0;

      // 1: reset held with all requests pending
      repeat (3) tick();
      check_out("rst_hold", 8'h00, 3'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      arb_if.req = 8'h00;
      tick();
      check_out("idle_noreq", 8'h00, 3'd0, 1'b0, 1'b0);

      // 2: single requester, done release, regrant after bubble
      arb_if.req = 8'h08;
      tick();
      check_out("t2_grant", 8'h08, 3'd3, 1'b1, 1'b0);
      arb_if.done = 1'b1;
      tick();
      arb_if.done = 1'b0;
      check_out("t2_bubble", 8'h00, 3'd0, 1'b0, 1'b0);
      tick();
      check_out("t2_regrant", 8'h08, 3'd3, 1'b1, 1'b0);
      arb_if.req = 8'h00;
      tick();
      check_out("t2_drop", 8'h00, 3'd0, 1'b0, 1'b0);

      // 3: full rotation from pointer 0
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      arb_if.req = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         tick();
         check($sformatf("t3_grant%0d", i), 16'(arb_if.grant), 16'(8'h01 << (i % 8)));
         check($sformatf("t3_sel%0d", i), 16'(arb_if.sel), 16'(i % 8));
         arb_if.done = 1'b1;
         tick();
         arb_if.done = 1'b0;
         check($sformatf("t3_gap%0d", i), 16'(arb_if.grant), 16'h0000);
      end

      // 4: forced release after 4 cycles, then resume from ptr=6
      arb_if.req = 8'h20;
      tick();
      check_out("t4_hold0", 8'h20, 3'd5, 1'b1, 1'b0);
      for (int i = 1; i < 4; i++) begin
         tick();
         check_out($sformatf("t4_hold%0d", i), 8'h20, 3'd5, 1'b1, 1'b0);
      end
      tick();
      check_out("t4_timeout", 8'h00, 3'd0, 1'b0, 1'b1);
      arb_if.req = 8'h60;
      tick();
      check_out("t4_next", 8'h40, 3'd6, 1'b1, 1'b0);

      // 5: asynchronous reset mid-grant
      arb_if.req = 8'h00;
      tick();
      arb_if.req = 8'h10;
      tick();
      check_out("t5_grant", 8'h10, 3'd4, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_out("t5_async", 8'h00, 3'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      arb_if.req = 8'hFF;
      tick();
      check_out("t5_first", 8'h01, 3'd0, 1'b1, 1'b0);

      // 6: request drop release, wrap search from ptr=3
      arb_if.done = 1'b1;
      tick();
      arb_if.done = 1'b0;
      arb_if.req = 8'h04;
      tick();
      check_out("t6_grant", 8'h04, 3'd2, 1'b1, 1'b0);
      arb_if.req = 8'h00;
      tick();
      check_out("t6_drop", 8'h00, 3'd0, 1'b0, 1'b0);
      arb_if.req = 8'h05;
      tick();
      check_out("t6_wrap", 8'h01, 3'd0, 1'b1, 1'b0);

      // done coinciding with the hold limit is a normal release
      repeat (3) tick();
      check_out("t7_last", 8'h01, 3'd0, 1'b1, 1'b0);
      arb_if.done = 1'b1;
      tick();
      arb_if.done = 1'b0;
      check_out("t7_done_limit", 8'h00, 3'd0, 1'b0, 1'b0);
      arb_if.req = 8'h00;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
